// File: rtl/mem_map_pkg.sv
// mem_map_pkg: shared memory map, FSM state encoding and port/region types
// for the two-port memory arbiter.
package mem_map_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_WAIT,
      ST_DONE
   } arb_state_e;

   typedef enum logic {
      PORT_A = 1'b0,
      PORT_B = 1'b1
   } port_e;

   // One-hot region select; exactly one bit is set for any address.
   typedef struct packed {
      logic none;
      logic font;
      logic vram;
      logic prg;
   } region_sel_t;

   // Region hit when (addr & MASK) == BASE.
   localparam logic [15:0] PRG_BASE  = 16'h0000;
   localparam logic [15:0] PRG_MASK  = 16'h8000;
   localparam logic [15:0] FONT_BASE = 16'hE000;
   localparam logic [15:0] FONT_MASK = 16'hF000;
   localparam logic [15:0] VRAM_BASE = 16'hF000;
   localparam logic [15:0] VRAM_MASK = 16'hF000;

   function automatic logic in_region(input logic [15:0] addr,
                                      input logic [15:0] base,
                                      input logic [15:0] mask);
      return (addr & mask) == base;
   endfunction

endpackage

// File: rtl/mem_region_decode.sv
// mem_region_decode: maps a 16-bit address to a one-hot region select
// (program / video / font / unmapped).
module mem_region_decode
   import mem_map_pkg::*;
(
   input  logic [15:0] ADDR,
   output region_sel_t REGION_SEL
);

   logic hit_prg;
   logic hit_vram;
   logic hit_font;

   // Purely combinational decode; 8000-DFFF falls through to none.
   always_comb begin
      hit_prg         = in_region(ADDR, PRG_BASE, PRG_MASK);
      hit_vram        = in_region(ADDR, VRAM_BASE, VRAM_MASK);
      hit_font        = in_region(ADDR, FONT_BASE, FONT_MASK);
      REGION_SEL      = '0;
      REGION_SEL.prg  = hit_prg;
      REGION_SEL.vram = hit_vram;
      REGION_SEL.font = hit_font;
      REGION_SEL.none = !(hit_prg || hit_vram || hit_font);
   end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates a CPU port (A) and a loader/DMA port (B) onto one
// shared memory bus with per-region write enables and read-data muxing.
// Build option ARB_ROUND_ROBIN_EN: simultaneous requests go to the port not
// granted last; otherwise port A always wins and no last-winner state exists.
module mem_arbiter
   import mem_map_pkg::*;
#(
   parameter int unsigned RD_LATENCY = 1
) (
   input  logic        CLOCK,
   input  logic        RESET_N,
   input  logic        A_REQ,
   input  logic        A_WREN,
   input  logic [15:0] A_ADDR,
   input  logic [7:0]  A_WDATA,
   output logic        A_ACK,
   output logic [7:0]  A_RDATA,
   input  logic        B_REQ,
   input  logic        B_WREN,
   input  logic [15:0] B_ADDR,
   input  logic [7:0]  B_WDATA,
   output logic        B_ACK,
   output logic [7:0]  B_RDATA,
   output logic [15:0] MEM_ADDR,
   output logic [7:0]  MEM_WDATA,
   output logic        WREN_PRG,
   output logic        WREN_VRAM,
   output logic        WREN_FONT,
   input  logic [7:0]  Q_PRG,
   input  logic [7:0]  Q_VRAM,
   input  logic [7:0]  Q_FONT
);

   // WAIT counts down from RD_LATENCY-1 to 0.
   localparam logic [1:0] WAIT_INIT = 2'(RD_LATENCY - 1);

   arb_state_e  state_q, state_d;
   port_e       winner_q, winner_d;
   logic        wren_q, wren_d;
   logic [15:0] addr_q, addr_d;
   logic [7:0]  wdata_q, wdata_d;
   logic [1:0]  wait_cnt_q, wait_cnt_d;
   logic [7:0]  a_rdata_q, a_rdata_d;
   logic [7:0]  b_rdata_q, b_rdata_d;
`ifdef ARB_ROUND_ROBIN_EN
   port_e       last_winner_q, last_winner_d;
`endif

   port_e       grant;
   region_sel_t region_sel;
   logic [7:0]  q_sel;
   logic        wr_strobe;

   mem_region_decode u_decode (
      .ADDR       (addr_q),
      .REGION_SEL (region_sel)
   );

   // Pick the port to serve if the FSM is idle this cycle.
   always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
      if (A_REQ && B_REQ) begin
         grant = (last_winner_q == PORT_A) ? PORT_B : PORT_A;
      end else begin
         grant = A_REQ ? PORT_A : PORT_B;
      end
`else
      grant = A_REQ ? PORT_A : PORT_B;
`endif
   end

   // Read-data mux for the latched address; unmapped reads return zero.
   always_comb begin
      case (1'b1)
         region_sel.prg:  q_sel = Q_PRG;
         region_sel.vram: q_sel = Q_VRAM;
         region_sel.font: q_sel = Q_FONT;
         region_sel.none: q_sel = '0;
         default:         q_sel = '0;
      endcase
   end

   // Next-state logic: latch winner in IDLE, strobe in ACCESS, count WAIT, ack in DONE.
   always_comb begin
      state_d    = state_q;
      winner_d   = winner_q;
      wren_d     = wren_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      wait_cnt_d = wait_cnt_q;
      a_rdata_d  = a_rdata_q;
      b_rdata_d  = b_rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
      last_winner_d = last_winner_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (A_REQ || B_REQ) begin
               winner_d = grant;
               state_d  = ST_ACCESS;
`ifdef ARB_ROUND_ROBIN_EN
               last_winner_d = grant;
`endif
               if (grant == PORT_A) begin
                  wren_d  = A_WREN;
                  addr_d  = A_ADDR;
                  wdata_d = A_WDATA;
               end else begin
                  wren_d  = B_WREN;
                  addr_d  = B_ADDR;
                  wdata_d = B_WDATA;
               end
            end
         end
         ST_ACCESS: begin
            wait_cnt_d = WAIT_INIT;
            state_d    = wren_q ? ST_DONE : ST_WAIT;
         end
         ST_WAIT: begin
            if (wait_cnt_q == 2'd0) begin
               state_d = ST_DONE;
               if (winner_q == PORT_A) begin
                  a_rdata_d = q_sel;
               end else begin
                  b_rdata_d = q_sel;
               end
            end else begin
               wait_cnt_d = wait_cnt_q - 2'd1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any transaction in flight.
   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q    <= ST_IDLE;
         winner_q   <= PORT_B;
         wren_q     <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         wait_cnt_q <= '0;
         a_rdata_q  <= '0;
         b_rdata_q  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
         last_winner_q <= PORT_B;
`endif
      end else begin
         state_q    <= state_d;
         winner_q   <= winner_d;
         wren_q     <= wren_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         wait_cnt_q <= wait_cnt_d;
         a_rdata_q  <= a_rdata_d;
         b_rdata_q  <= b_rdata_d;
`ifdef ARB_ROUND_ROBIN_EN
         last_winner_q <= last_winner_d;
`endif
      end
   end

   // Outputs decode from registered state, so reset clears them without a clock.
   always_comb begin
      wr_strobe = (state_q == ST_ACCESS) && wren_q;
      WREN_PRG  = wr_strobe && region_sel.prg;
      WREN_VRAM = wr_strobe && region_sel.vram;
      WREN_FONT = wr_strobe && region_sel.font;
      MEM_ADDR  = (state_q == ST_IDLE) ? '0 : addr_q;
      MEM_WDATA = (state_q == ST_IDLE) ? '0 : wdata_q;
      A_ACK     = (state_q == ST_DONE) && (winner_q == PORT_A);
      B_ACK     = (state_q == ST_DONE) && (winner_q == PORT_B);
      A_RDATA   = a_rdata_q;
      B_RDATA   = b_rdata_q;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter RD_LATENCY, default 1, memory read latency in cycles, legal 1..4.
REQ-002 SHALL have ports CLOCK in 1, the single clock; RESET_N in 1, asynchronous active-low reset.
REQ-003 SHALL have A_REQ in 1, A_WREN in 1, A_ADDR in 16 and A_WDATA in 8: the CPU port request, held until A_ACK.
REQ-004 SHALL have A_ACK out 1, a one-cycle completion pulse, and A_RDATA out 8, read data valid while A_ACK=1.
REQ-005 SHALL have B_REQ, B_WREN, B_ADDR, B_WDATA, B_ACK and B_RDATA, identical to port A, for the loader/DMA port.
REQ-006 SHALL have outputs MEM_ADDR 16 and MEM_WDATA 8, the shared address and write bus.
REQ-007 SHALL have outputs WREN_PRG, WREN_VRAM and WREN_FONT, 1 each, the per-region write enables.
REQ-008 SHALL have inputs Q_PRG, Q_VRAM and Q_FONT, 8 each, the region read data.

Function
REQ-009 SHALL decode regions: 0000-7FFF program, E000-EFFF font, F000-FFFF video, 8000-DFFF unmapped.
REQ-010 SHALL implement states IDLE, ACCESS, WAIT and DONE.
REQ-011 IDLE: any REQ high SHALL latch the winner's address, data and wren, record the winner, and go to ACCESS.
REQ-012 ACCESS (one cycle): SHALL drive MEM_ADDR/MEM_WDATA from the latch; on a write, exactly one region WREN is high for this cycle only; next state DONE for a write, WAIT for a read.
REQ-013 WAIT SHALL last RD_LATENCY cycles, then register the decoded region Q into the winner's RDATA and go to DONE.
REQ-014 DONE SHALL pulse the winner's ACK for one cycle, ignore all REQ, and return to IDLE.
REQ-015 Latency from the REQ-sampled cycle N SHALL be: write ACK in N+2; read ACK in N+2+RD_LATENCY.
REQ-016 An unmapped write SHALL assert no WREN; an unmapped read SHALL return 0x00; both SHALL still be acked.
REQ-017 The loser of a simultaneous request SHALL keep REQ pending and be served on its next IDLE win.
REQ-018 Non-winner ACK SHALL stay 0; non-winner RDATA SHALL hold its last value.
REQ-019 MEM_ADDR/MEM_WDATA SHALL hold the latched values from ACCESS through DONE, and be 0x0000/0x00 in IDLE.
REQ-020 REQ changes outside IDLE SHALL have no effect on the transaction in flight.

Reset
REQ-021 RESET_N low SHALL immediately force IDLE, clear all ACK and WREN outputs, RDATA, MEM_ADDR and MEM_WDATA to 0, and set last-winner to B.
REQ-022 Reset mid-transaction SHALL abort it with no ACK; any write WREN drops asynchronously.

Configuration
REQ-023 With ARB_ROUND_ROBIN_EN defined, simultaneous requests SHALL be granted to the port not granted last.
REQ-024 Without ARB_ROUND_ROBIN_EN, port A SHALL always win simultaneous requests (fixed priority), and no last-winner register SHALL exist.

Structure
REQ-025 Region base/mask constants and the state encoding SHALL live in shared package mem_map_pkg.
REQ-026 Address decode SHALL be sub-module mem_region_decode (ADDR in; region select out, one-hot: prg/vram/font/none), reused by the top level.

Verification
REQ-027 A write 0xF005<=0x41 -> WREN_VRAM high exactly one cycle with MEM_ADDR=F005, MEM_WDATA=41; A_ACK at N+2.
REQ-028 B read 0x0123, Q_PRG=0x5A, RD_LATENCY=2 -> B_RDATA=5A with B_ACK at N+4; A_ACK stays 0.
REQ-029 A and B both request in the same cycle, ARB_ROUND_ROBIN_EN defined -> A served first, then B; with B re-requesting continuously the grants alternate A,B,A,B. Without the macro -> A always first.
REQ-030 Unmapped region: write 0x9000 -> no WREN, ACK at N+2; read 0xD000 -> RDATA=00.
REQ-031 Reset mid-transaction: RESET_N low during ACCESS of a font write -> WREN_FONT drops in the same cycle, no ACK; after release, a new A read completes normally.
